rv_hazard_ctrl: RTL
===================

Name: rv_hazard_ctrl

Overview:
Pipeline hazard controller for the ALU1 stage.
- Tracks destination registers of all in-flight instructions (ALU1, ALU2, MEMORY, WRITE, WR_BACK).
- Generates the registered rs1/rs2 bypass selects that the ALU1 stage consumes.
- Sequences load-use stalls with a small FSM.
- Issues decode-hold, ALU1-bubble and front-end flush controls on redirect and trap.

Parameters:
LOAD_LATE, 1, 1 = load data first available at WRITE stage; 0 = available at MEMORY stage
TRAP_FLUSH_CYCLES, 2, cycles o_flush_front stays asserted after i_trap (1..7)

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_dec_valid  in  1  decode stage holds a valid instruction
i_dec_rs1  in  5  decode rs1 index
i_dec_rs2  in  5  decode rs2 index
i_dec_use_rs1  in  1  instruction reads rs1
i_dec_use_rs2  in  1  instruction reads rs2
i_dec_rd  in  5  decode rd index
i_dec_reg_write  in  1  instruction writes rd
i_dec_load  in  1  instruction is a load (result from memory)
i_pc_change  in  1  redirect resolved in ALU2 (mispredict/jump)
i_trap  in  1  instruction in ALU2 traps
o_rs1_bp  out  ctrl_rs_bp_t  one-hot {alu2,memory,write,wr_back} bypass for instruction now in ALU1
o_rs2_bp  out  ctrl_rs_bp_t  same for rs2
o_stall_dec  out  1  hold fetch/decode registers this cycle
o_flush_alu1  out  1  load bubble into ALU1 register
o_flush_front  out  1  flush fetch/decode

Behaviour:
- Clock/reset: one clock i_clk; reset i_reset_n is asynchronous, active-low.
- Reset state:
  - All tracking entries invalid.
  - o_rs1_bp and o_rs2_bp = 0.
  - Stall FSM in IDLE; trap counter = 0.
  - Combinational outputs therefore 0 while i_pc_change, i_trap and i_dec_valid are 0.
- Tracking pipe: five entries E_ALU1..E_WB, each {valid, rd, reg_write, load}. Every cycle they shift one stage toward WB.
  - E_ALU1 loads the decode fields when i_dec_valid & !o_stall_dec & !o_flush_alu1. Otherwise it loads a bubble (valid=0).
- Match rule: stage S matches rsN when S.valid & S.reg_write & S.rd==rsN & rsN!=0 & use_rsN.
- Bypass, computed at decode and registered into o_rsN_bp on the same edge as the ALU1 register:
  - E_ALU1 match -> alu2; else E_ALU2 -> memory; else E_MEM -> write; else E_WR -> wr_back; else 0.
  - Youngest match wins; exactly zero or one bit is set.
  - Registered value is 0 whenever a bubble enters ALU1.
- Load-use: required stall cycles N = max over matching load entries.
  - LOAD_LATE=1: E_ALU1 -> 2, E_ALU2 -> 1.
  - LOAD_LATE=0: E_ALU1 -> 1.
- Stall FSM states: IDLE, STALL2, STALL1.
  - IDLE, N=2: o_stall_dec=1, o_flush_alu1=1, next STALL1? No: next STALL2 is not used; go to STALL1 after one cycle, giving two stalled cycles total (IDLE cycle + STALL1 cycle).
  - IDLE, N=1: stall this cycle, next IDLE.
  - STALL1: stall this cycle, next IDLE.
  - Detection is re-evaluated every cycle. Decode issues the cycle after the last stall, and the bypass captured then selects write or wr_back.
- Redirect, i_pc_change:
  - o_flush_alu1=1 and o_flush_front=1 for that cycle.
  - E_ALU1 is invalidated as it moves to ALU2. The redirecting instruction proceeds to MEMORY.
  - Stall FSM forced to IDLE.
- Trap, i_trap:
  - Same flushes as redirect; additionally the trapping entry is invalidated.
  - Trap counter is loaded with TRAP_FLUSH_CYCLES-1. o_flush_front stays 1 while the counter is nonzero; it decrements each cycle.
- Priority: trap > redirect > load-use stall > issue.
  - A trap during a stall cancels the stall.
  - Simultaneous i_trap and i_pc_change is treated as a trap.
- Reset mid-operation immediately returns all state to reset values. No bypass is asserted on the first post-reset cycle.

Decomposition:
- Shared struct header:
  - hz_entry_t {valid, rd[4:0], reg_write, load}.
  - Stall FSM enum hz_state_t.
  - ctrl_rs_bp_t stays where it is already defined.
- Sub-module rv_hazard_cmp: one instance per source operand.
  - Inputs: rs, use, four entries.
  - Outputs: one-hot bypass and load-stall count.

Test Plan:
- add x1 issued, then add x2,x1,x1 next cycle -> in ALU1 cycle o_rs1_bp=alu2, o_rs2_bp=alu2. Distances 2/3/4 -> memory/write/wr_back; distance 5 -> 0.
- Producer writes x0, consumer reads x0 -> bypasses 0. Producer with reg_write=0 -> 0.
- LOAD_LATE=1, lw x5 then add x6,x5 -> o_stall_dec and o_flush_alu1 high 2 cycles; add then enters ALU1 with o_rs1_bp=write. Load at distance 2 -> 1 stall; LOAD_LATE=0 distance 1 -> 1 stall, bypass memory.
- i_pc_change one cycle with dependent instruction in ALU1 -> flushes high 1 cycle; later consumer of that killed rd gets no bypass from it.
- i_trap, TRAP_FLUSH_CYCLES=3 -> o_flush_front high 3 cycles; trap during 2-cycle load stall -> stall aborted, FSM IDLE.
- Deassert i_reset_n asynchronously mid-stall -> all outputs 0 without a clock edge; first issued instruction after release sees bypass 0.

Source files
------------

// File: rtl/rv_hazard_ctrl_pkg.sv
// rtl/rv_hazard_ctrl_pkg.sv - shared types and helpers for the ALU1 hazard controller
package rv_hazard_ctrl_pkg;

  // One-hot bypass select for an operand of the instruction now in ALU1
  typedef struct packed {
    logic alu2;
    logic memory;
    logic write;
    logic wr_back;
  } ctrl_rs_bp_t;

  // Destination-register record for one in-flight pipeline stage
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       load;
  } hz_entry_t;

  // Load-use stall sequencer states
  typedef enum logic [1:0] {
    HZ_IDLE   = 2'd0,
    HZ_STALL2 = 2'd1,
    HZ_STALL1 = 2'd2
  } hz_state_t;

  // Tracking pipe layout: index 0 is the youngest in-flight instruction
  localparam int HZ_STAGES = 5;
  localparam int HZ_FWD    = 4;
  localparam int E_ALU1    = 0;
  localparam int E_ALU2    = 1;
  localparam int E_MEM     = 2;
  localparam int E_WR      = 3;
  localparam int E_WB      = 4;

  localparam hz_entry_t   HZ_BUBBLE = '{valid: 1'b0, rd: 5'd0, reg_write: 1'b0, load: 1'b0};
  localparam ctrl_rs_bp_t BP_NONE   = '{alu2: 1'b0, memory: 1'b0, write: 1'b0, wr_back: 1'b0};

  // An in-flight entry supplies an operand only if it really writes a nonzero rd
  function automatic logic hz_match(input hz_entry_t e, input logic [4:0] rs, input logic use_rs);
    return e.valid && e.reg_write && (e.rd == rs) && (rs != 5'd0) && use_rs;
  endfunction

  // Stall cycles a consumer needs behind a load sitting at a given tracking stage
  function automatic logic [1:0] hz_load_weight(input logic load_late, input int stage);
    logic [1:0] w;
    w = 2'd0;
    if (stage == E_ALU1) begin
      w = load_late ? 2'd2 : 2'd1;
    end else if (stage == E_ALU2) begin
      w = load_late ? 2'd1 : 2'd0;
    end
    return w;
  endfunction

endpackage

// File: rtl/rv_hazard_ctrl_cmp.sv
// rtl/rv_hazard_ctrl_cmp.sv - per-operand bypass select and load-use stall count
module rv_hazard_cmp
  import rv_hazard_ctrl_pkg::*;
#(
  parameter bit LOAD_LATE = 1'b1
) (
  input  logic [4:0]  rs,
  input  logic        use_rs,
  input  hz_entry_t   ent [HZ_FWD],
  output ctrl_rs_bp_t bp,
  output logic [1:0]  load_stall
);

  logic [HZ_FWD-1:0] hit;
  logic [1:0]        cand [HZ_FWD];

  for (genvar g = 0; g < HZ_FWD; g++) begin : g_stage
    assign hit[g]  = hz_match(ent[g], rs, use_rs);
    assign cand[g] = (hit[g] && ent[g].load) ? hz_load_weight(LOAD_LATE, g) : 2'd0;
  end

  // Youngest producer wins so the ALU1 operand always sees the newest value
  always_comb begin
    bp = BP_NONE;
    if (hit[E_ALU1]) begin
      bp.alu2 = 1'b1;
    end else if (hit[E_ALU2]) begin
      bp.memory = 1'b1;
    end else if (hit[E_MEM]) begin
      bp.write = 1'b1;
    end else if (hit[E_WR]) begin
      bp.wr_back = 1'b1;
    end
  end

  // Longest wait over every matching load still short of its data stage
  always_comb begin
    load_stall = 2'd0;
    for (int i = 0; i < HZ_FWD; i++) begin
      if (cand[i] > load_stall) begin
        load_stall = cand[i];
      end
    end
  end

endmodule

// File: rtl/rv_hazard_ctrl.sv
// rtl/rv_hazard_ctrl.sv - ALU1 hazard controller: tracking pipe, bypass, stalls, flushes
module rv_hazard_ctrl
  import rv_hazard_ctrl_pkg::*;
#(
  parameter bit          LOAD_LATE         = 1'b1,
  parameter int unsigned TRAP_FLUSH_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_dec_valid,
  input  logic [4:0]  i_dec_rs1,
  input  logic [4:0]  i_dec_rs2,
  input  logic        i_dec_use_rs1,
  input  logic        i_dec_use_rs2,
  input  logic [4:0]  i_dec_rd,
  input  logic        i_dec_reg_write,
  input  logic        i_dec_load,
  input  logic        i_pc_change,
  input  logic        i_trap,
  output ctrl_rs_bp_t o_rs1_bp,
  output ctrl_rs_bp_t o_rs2_bp,
  output logic        o_stall_dec,
  output logic        o_flush_alu1,
  output logic        o_flush_front
);

  localparam logic [2:0] TRAP_RELOAD = 3'(TRAP_FLUSH_CYCLES - 1);

  hz_entry_t   trk [HZ_STAGES];
  hz_entry_t   fwd [HZ_FWD];
  hz_entry_t   dec_entry;
  hz_state_t   state;
  hz_state_t   state_nxt;
  logic [2:0]  trap_cnt;
  ctrl_rs_bp_t bp1;
  ctrl_rs_bp_t bp2;
  logic [1:0]  ls1;
  logic [1:0]  ls2;
  logic [1:0]  need;
  logic        kill_alu1;
  logic        kill_alu2;
  logic        stall_req;
  logic        issue;

  // A trap also kills the ALU2 instruction; a redirect lets it retire
  assign kill_alu1 = i_pc_change | i_trap;
  assign kill_alu2 = i_trap;

  assign dec_entry = '{valid: 1'b1, rd: i_dec_rd, reg_write: i_dec_reg_write, load: i_dec_load};

  for (genvar g = 0; g < HZ_FWD; g++) begin : g_fwd
    assign fwd[g] = trk[g];
  end

  rv_hazard_cmp #(
    .LOAD_LATE (LOAD_LATE)
  ) u_cmp_rs1 (
    .rs         (i_dec_rs1),
    .use_rs     (i_dec_valid & i_dec_use_rs1),
    .ent        (fwd),
    .bp         (bp1),
    .load_stall (ls1)
  );

  rv_hazard_cmp #(
    .LOAD_LATE (LOAD_LATE)
  ) u_cmp_rs2 (
    .rs         (i_dec_rs2),
    .use_rs     (i_dec_valid & i_dec_use_rs2),
    .ent        (fwd),
    .bp         (bp2),
    .load_stall (ls2)
  );

  assign need = (ls1 > ls2) ? ls1 : ls2;

  // Stall sequencing; trap and redirect override any pending load-use stall
  always_comb begin
    stall_req = 1'b0;
    state_nxt = HZ_IDLE;
    if (!kill_alu1) begin
      stall_req = (state != HZ_IDLE) || (need != 2'd0);
      case (state)
        HZ_IDLE:   state_nxt = (need == 2'd2) ? HZ_STALL1 : HZ_IDLE;
        HZ_STALL2: state_nxt = HZ_STALL1;
        HZ_STALL1: state_nxt = (need == 2'd2) ? HZ_STALL1 : HZ_IDLE;
        default:   state_nxt = HZ_IDLE;
      endcase
    end
  end

  assign o_stall_dec   = stall_req;
  assign o_flush_alu1  = stall_req | kill_alu1;
  assign o_flush_front = kill_alu1 | (trap_cnt != 3'd0);
  assign issue         = i_dec_valid & ~o_flush_alu1;

  // Shift the tracking pipe toward write-back, inserting bubbles on kills
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      trk[E_ALU1] <= HZ_BUBBLE;
      trk[E_ALU2] <= HZ_BUBBLE;
      trk[E_MEM]  <= HZ_BUBBLE;
      trk[E_WR]   <= HZ_BUBBLE;
      trk[E_WB]   <= HZ_BUBBLE;
    end else begin
      trk[E_ALU1] <= issue ? dec_entry : HZ_BUBBLE;
      trk[E_ALU2] <= kill_alu1 ? HZ_BUBBLE : trk[E_ALU1];
      trk[E_MEM]  <= kill_alu2 ? HZ_BUBBLE : trk[E_ALU2];
      trk[E_WR]   <= trk[E_MEM];
      trk[E_WB]   <= trk[E_WR];
    end
  end

  // Bypass selects travel with the instruction into the ALU1 register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_rs1_bp <= BP_NONE;
      o_rs2_bp <= BP_NONE;
    end else begin
      o_rs1_bp <= issue ? bp1 : BP_NONE;
      o_rs2_bp <= issue ? bp2 : BP_NONE;
    end
  end

  // Stall state register and post-trap front-end flush countdown
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= HZ_IDLE;
      trap_cnt <= 3'd0;
    end else begin
      state <= state_nxt;
      if (i_trap) begin
        trap_cnt <= TRAP_RELOAD;
      end else if (trap_cnt != 3'd0) begin
        trap_cnt <= trap_cnt - 3'd1;
      end
    end
  end

endmodule
